// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_pkg;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC8 = 3'd2;
    localparam logic [2:0] WB_HI  = 3'd3;
    localparam logic [2:0] WB_LO  = 3'd4;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } mult_state_e;

    // M has the younger result, so it takes priority over W; $0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src_reg,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src_reg))
            return FWD_M;
        else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src_reg))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mult_tracker.sv
// rtl/mult_tracker.sv - multiplier busy FSM, timeout watchdog and pending flag
module mult_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic MultStartE,
    input  logic MultDoneE,
    output logic mult_busy,
    output logic mult_err,
    output logic pending
);

    localparam int TW = $clog2(MULT_TIMEOUT) + 1;
    localparam logic [TW-1:0] LIMIT = TW'(MULT_TIMEOUT);
    localparam logic [TW-1:0] LAST  = TW'(MULT_TIMEOUT - 1);

    mult_state_e      state;
    mult_state_e      state_next;
    logic [TW-1:0]    busy_cycles;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= MULT_IDLE;
        else
            state <= state_next;
    end

    // Next state; a done that coincides with a new start keeps the tracker busy
    always_comb begin
        state_next = state;
        case (state)
            MULT_IDLE: if (MultStartE) state_next = MULT_BUSY;
            MULT_BUSY: if (MultDoneE && !MultStartE) state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    // Count BUSY cycles since the last start/done; the error flag is sticky and the FSM is left busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
            mult_err    <= 1'b0;
        end else begin
            if ((state != MULT_BUSY) || MultDoneE)
                busy_cycles <= '0;
            else if (busy_cycles != LIMIT)
                busy_cycles <= busy_cycles + 1'b1;
            if ((state == MULT_BUSY) && !MultDoneE && (busy_cycles == LAST))
                mult_err <= 1'b1;
        end
    end

    assign mult_busy = (state == MULT_BUSY);
    assign pending   = (mult_busy || MultStartE) && !MultDoneE;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding selects, load-use/branch/multiply stalls and event counters
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MULT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [1:0]       branchD,
    input  logic             MultD,
    input  logic             MfHiLoD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic [2:0]       WBSrcE,
    input  logic             MultStartE,
    input  logic             MultDoneE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic [2:0]       WBSrcM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mult_busy,
    output logic             mult_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic lwstall;
    logic brstall;
    logic multstall;
    logic pending;
    logic hazard;
    logic e_hits_d;
    logic m_load_hits_d;

    mult_tracker #(
        .MULT_TIMEOUT(MULT_TIMEOUT)
    ) u_mult_tracker (
        .clk       (clk),
        .rst       (rst),
        .MultStartE(MultStartE),
        .MultDoneE (MultDoneE),
        .mult_busy (mult_busy),
        .mult_err  (mult_err),
        .pending   (pending)
    );

    // Forwarding selects and hazard detection; a load to $0 may stall spuriously, which is harmless
    always_comb begin
        forwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        forwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        forwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
        forwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);

        lwstall = (WBSrcE == WB_MEM) && ((WriteRegE == RsD) || (WriteRegE == RtD));

        e_hits_d      = RegWriteE && (WriteRegE != 5'd0) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_load_hits_d = (WBSrcM == WB_MEM) && (WriteRegM != 5'd0) &&
                        ((WriteRegM == RsD) || (WriteRegM == RtD));
        brstall       = (branchD != BR_NONE) && (e_hits_d || m_load_hits_d);

        multstall = pending && (MfHiLoD || MultD);
        hazard    = lwstall || brstall || multstall;
    end

    assign stallF = hazard;
    assign stallD = hazard;
    assign flushE = hazard;

    // Saturating stall/flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flushE && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
